// File: rtl/cache_line_fill.sv
// cache_line_fill: optional dirty-line writeback followed by a block-by-block line fill and a one-cycle install pulse.
module cache_line_fill #(
  parameter int BLOCK_SIZE             = 32,
  parameter int NUM_OF_BLOCKS_PER_LINE = 4,
  parameter int ADDRESS_SIZE           = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         fill_req,
  input  logic [ADDRESS_SIZE-1:0]                      fill_addr,
  input  logic                                         wb_req,
  input  logic [ADDRESS_SIZE-1:0]                      wb_addr,
  input  logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] wb_line,
  output logic                                         mem_req,
  output logic                                         mem_we,
  output logic [ADDRESS_SIZE-1:0]                      mem_addr,
  output logic [BLOCK_SIZE-1:0]                        mem_wdata,
  input  logic                                         mem_ready,
  input  logic [BLOCK_SIZE-1:0]                        mem_rdata,
  output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] line_o,
  output logic [ADDRESS_SIZE-1:0]                      line_addr_o,
  output logic                                         write_line_o,
  output logic                                         busy
);
  localparam int OFF = $clog2(NUM_OF_BLOCKS_PER_LINE);
  localparam int LW  = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;
  localparam logic [ADDRESS_SIZE-1:0] OMASK = ADDRESS_SIZE'(NUM_OF_BLOCKS_PER_LINE - 1);
  localparam logic [1:0] IDLE = 2'd0, WRITEBACK = 2'd1, FILL = 2'd2, COMMIT = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [OFF-1:0]          cnt_q, cnt_d;
  logic [ADDRESS_SIZE-1:0] fill_base_q, fill_base_d, wb_base_q, wb_base_d;
  logic [LW-1:0]           wb_line_q, wb_line_d, line_q, line_d;
  logic [ADDRESS_SIZE-1:0] line_addr_q, line_addr_d, addr_q, addr_d;
  logic [BLOCK_SIZE-1:0]   wdata_q, wdata_d;
  logic                    req_q, req_d, we_q, we_d;
  logic                    done, last;

  assign done = req_q & mem_ready;
  assign last = cnt_q == {OFF{1'b1}};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_base_d = fill_base_q;
    wb_base_d   = wb_base_q;
    wb_line_d   = wb_line_q;
    line_d      = line_q;
    line_addr_d = line_addr_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (state_q == IDLE) begin
      if (fill_req) begin
        fill_base_d = fill_addr & ~OMASK;
        wb_base_d   = wb_addr & ~OMASK;
        wb_line_d   = wb_line;
        state_d     = wb_req ? WRITEBACK : FILL;
        cnt_d       = '0;
      end
    end else if (state_q == COMMIT) begin
      state_d = IDLE;
    end else begin
      if (done && state_q == FILL) line_d[cnt_q*BLOCK_SIZE +: BLOCK_SIZE] = mem_rdata;
      if (done && last) state_d = (state_q == WRITEBACK) ? FILL : COMMIT;
      if (done && last && state_q == FILL) line_addr_d = fill_base_q;
      cnt_d = done ? cnt_q + OFF'(1) : cnt_q;
      // The first beat of a transfer is issued one cycle after acceptance; later beats follow back to back.
      if (!req_q || done) begin
        req_d   = state_d != COMMIT;
        we_d    = state_d == WRITEBACK;
        addr_d  = req_d ? ((state_d == WRITEBACK ? wb_base_q : fill_base_q) | ADDRESS_SIZE'(cnt_d)) : '0;
        wdata_d = we_d ? wb_line_q[cnt_d*BLOCK_SIZE +: BLOCK_SIZE] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_base_q <= '0;
      wb_base_q   <= '0;
      wb_line_q   <= '0;
      line_q      <= '0;
      line_addr_q <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_base_q <= fill_base_d;
      wb_base_q   <= wb_base_d;
      wb_line_q   <= wb_line_d;
      line_q      <= line_d;
      line_addr_q <= line_addr_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign line_o       = line_q;
  assign line_addr_o  = line_addr_q;
  assign write_line_o = state_q == COMMIT;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: scoreboard bench; expected beats and lines are queued at request time and checked as the DUT produces them.
module tb_cache_line_fill;
  localparam int B = 32;
  localparam int N = 4;
  localparam int A = 32;

  logic clk = 1'b0, rst_n = 1'b0, fill_req = 1'b0, wb_req = 1'b0, mem_ready = 1'b0;
  logic [A-1:0] fill_addr = '0, wb_addr = '0, mem_addr, line_addr_o;
  logic [N*B-1:0] wb_line = '0, line_o;
  logic [B-1:0] mem_wdata, mem_rdata = '0;
  logic mem_req, mem_we, write_line_o, busy;

  cache_line_fill #(.BLOCK_SIZE(B), .NUM_OF_BLOCKS_PER_LINE(N), .ADDRESS_SIZE(A)) dut (
    .clk(clk), .rst_n(rst_n), .fill_req(fill_req), .fill_addr(fill_addr), .wb_req(wb_req),
    .wb_addr(wb_addr), .wb_line(wb_line), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .line_o(line_o),
    .line_addr_o(line_addr_o), .write_line_o(write_line_o), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic         we;
    logic [A-1:0] addr;
    logic [B-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  logic [N*B-1:0] eline_q[$];
  logic [A-1:0] eaddr_q[$];
  int checks = 0, errors = 0;
  int stall = 0, wl_count = 0, wl_cyc = 0, rd_done = 0, acc = 0;
  logic idle_ready = 1'b0;
  logic [B-1:0] rd_base = 32'hA0;
  logic [N*B-1:0] last_line = '0;
  logic [A-1:0] last_laddr = '0;

  // Memory responder and output monitor, evaluated on the falling edge.
  initial begin
    beat_t pb, cb, e;
    logic pr, prdy, r;
    int wc;
    pr = 1'b0; prdy = 1'b0; wc = 0; pb = '0;
    forever begin
      @(posedge clk);
      r = rst_n;
      @(negedge clk);
      cb = {mem_we, mem_addr, mem_wdata};
      if (!r) wc = 0;
      else if (pr && prdy) begin
        checks++;
        wc = 0;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got we=%0b addr=%h data=%h expected none", pb.we, pb.addr, pb.data);
        end else begin
          e = exp_q.pop_front();
          if (pb !== e) begin
            errors++;
            $display("FAIL beat got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                     pb.we, pb.addr, pb.data, e.we, e.addr, e.data);
          end
        end
        if (!pb.we) rd_done++;
      end else if (pr) begin
        checks++;
        if (mem_req !== 1'b1 || cb !== pb) begin
          errors++;
          $display("FAIL stall_stable got req=%0b we=%0b addr=%h data=%h expected req=1 we=%0b addr=%h data=%h",
                   mem_req, cb.we, cb.addr, cb.data, pb.we, pb.addr, pb.data);
        end
      end
      if (write_line_o) begin
        wl_count++;
        wl_cyc = cyc;
        checks++;
        if (eline_q.size() == 0) begin
          errors++;
          $display("FAIL write_line_unexpected got addr=%h line=%h expected no pulse", line_addr_o, line_o);
        end else begin
          last_line = eline_q.pop_front();
          last_laddr = eaddr_q.pop_front();
          if (line_o !== last_line || line_addr_o !== last_laddr) begin
            errors++;
            $display("FAIL commit_line got addr=%h line=%h expected addr=%h line=%h",
                     line_addr_o, line_o, last_laddr, last_line);
          end
        end
      end
      pr = mem_req;
      pb = cb;
      if (mem_req) begin
        if (wc >= stall) begin
          mem_ready = 1'b1;
          mem_rdata = rd_base + B'(mem_addr & 32'd3);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wc++;
        end
      end else begin
        mem_ready = idle_ready;
        mem_rdata = $urandom;
      end
      prdy = mem_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end

  task tick;
    @(negedge clk);
    #2;
  endtask

  task push_fill(input logic wb, input logic [A-1:0] fa, input logic [A-1:0] wa, input logic [N*B-1:0] wl);
    logic [A-1:0] fb, wbb;
    logic [N*B-1:0] ln;
    beat_t b;
    fb = {fa[A-1:2], 2'b00};
    wbb = {wa[A-1:2], 2'b00};
    if (wb)
      for (int k = 0; k < N; k++) begin
        b = {1'b1, wbb + A'(k), wl[k*B +: B]};
        exp_q.push_back(b);
      end
    for (int k = 0; k < N; k++) begin
      b = {1'b0, fb + A'(k), 32'h0};
      exp_q.push_back(b);
      ln[k*B +: B] = rd_base + B'(k);
    end
    eline_q.push_back(ln);
    eaddr_q.push_back(fb);
  endtask

  task do_fill(input logic wb, input logic [A-1:0] fa, input logic [A-1:0] wa, input logic [N*B-1:0] wl);
    fill_req = 1'b1;
    wb_req = wb;
    fill_addr = fa;
    wb_addr = wa;
    wb_line = wl;
    push_fill(wb, fa, wa, wl);
    tick;
    fill_req = 1'b0;
    wb_req = $urandom;
    fill_addr = $urandom;
    wb_addr = $urandom;
    wb_line = {$urandom, $urandom, $urandom, $urandom};
    acc = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept got busy=%0b expected 1", busy);
    end
  endtask

  task wait_wl(input int n0, input int lat);
    for (int i = 0; i < 400 && wl_count == n0; i++) tick;
    checks++;
    if (wl_count == n0) begin
      errors++;
      $display("FAIL commit_timeout got no write_line_o expected one");
    end else if (lat > 0 && wl_cyc - acc != lat) begin
      errors++;
      $display("FAIL commit_latency got %0d edges expected %0d", wl_cyc - acc, lat);
    end
    repeat (3) tick;
    checks++;
    if (wl_count !== n0 + 1 || busy !== 1'b0 || exp_q.size() != 0 || eline_q.size() != 0) begin
      errors++;
      $display("FAIL after_commit got pulses=%0d busy=%0b beats_left=%0d expected pulses=%0d busy=0 beats_left=0",
               wl_count - n0, busy, exp_q.size(), 1);
    end
    checks++;
    if (line_o !== last_line || line_addr_o !== last_laddr) begin
      errors++;
      $display("FAIL line_hold got addr=%h line=%h expected addr=%h line=%h", line_addr_o, line_o, last_laddr, last_line);
    end
  endtask

  task check_zero(input string name);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, line_o, line_addr_o, write_line_o, busy} !== '0) begin
      errors++;
      $display("FAIL %s got req=%0b we=%0b addr=%h wdata=%h line=%h laddr=%h wl=%0b busy=%0b expected all 0",
               name, mem_req, mem_we, mem_addr, mem_wdata, line_o, line_addr_o, write_line_o, busy);
    end
  endtask

  task test_reset;
    rst_n = 1'b0;
    fill_req = 1'b1;
    wb_req = 1'b1;
    fill_addr = 32'hDEAD_BEEF;
    idle_ready = 1'b1;
    repeat (3) tick;
    check_zero("reset_state");
  endtask

  task test_clean;
    stall = 0;
    rd_base = 32'hA0;
    rst_n = 1'b1;
    do_fill(1'b0, 32'h13, 32'h0, '0);
    wait_wl(wl_count, 5);
  endtask

  task test_dirty;
    rd_base = 32'hB0;
    do_fill(1'b1, 32'h40, 32'h25, {32'h14, 32'h13, 32'h12, 32'h11});
    wait_wl(wl_count, 9);
  endtask

  task test_stall;
    stall = 3;
    idle_ready = 1'b0;
    rd_base = 32'hA0;
    do_fill(1'b0, 32'h13, 32'h0, '0);
    wait_wl(wl_count, 0);
    stall = 2;
    rd_base = 32'hC0;
    do_fill(1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000});
    wait_wl(wl_count, 0);
  endtask

  task test_busy;
    int n;
    stall = 1;
    n = wl_count;
    do_fill(1'b0, 32'h80, 32'h0, '0);
    repeat (4) tick;
    fill_req = 1'b1;
    wb_req = 1'b1;
    fill_addr = 32'h1234;
    tick;
    fill_req = 1'b0;
    wait_wl(n, 0);
  endtask

  task test_back_to_back;
    int n;
    stall = 0;
    idle_ready = 1'b1;
    n = wl_count;
    do_fill(1'b0, 32'h200, 32'h0, '0);
    for (int i = 0; i < 100 && wl_count == n; i++) tick;
    checks++;
    if (wl_count != n + 1 || write_line_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got pulses=%0d wl=%0b expected pulses=1 wl=1", wl_count - n, write_line_o);
    end
    fill_req = 1'b1;
    wb_req = 1'b0;
    fill_addr = 32'h305;
    push_fill(1'b0, 32'h305, 32'h0, '0);
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap got busy=%0b expected 0", busy);
    end
    tick;
    fill_req = 1'b0;
    acc = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%0b expected 1", busy);
    end
    wait_wl(n + 1, 5);
  endtask

  task test_mid_reset;
    int n, r0;
    stall = 0;
    n = wl_count;
    r0 = rd_done;
    do_fill(1'b0, 32'h55, 32'h0, '0);
    for (int i = 0; i < 100 && rd_done < r0 + 2; i++) tick;
    rst_n = 1'b0;
    tick;
    check_zero("mid_reset");
    exp_q.delete();
    eline_q.delete();
    eaddr_q.delete();
    repeat (3) tick;
    checks++;
    if (wl_count != n) begin
      errors++;
      $display("FAIL mid_reset_pulse got %0d pulses expected 0", wl_count - n);
    end
    rst_n = 1'b1;
    tick;
    rd_base = 32'hD0;
    do_fill(1'b0, 32'h66, 32'h0, '0);
    wait_wl(n, 5);
  endtask

  initial begin
    test_reset;
    test_clean;
    test_dirty;
    test_stall;
    test_busy;
    test_back_to_back;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_line_fill.md
CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
REQ-001 The block SHALL have these parameters: BLOCK_SIZE, default 32, bits per block; NUM_OF_BLOCKS_PER_LINE, default 4, blocks per line (power of 2, at least 2); ADDRESS_SIZE, default 32, block-address width.
REQ-002 clk  in  1  rising-edge clock; rst_n  in  1  reset, synchronous, active-low.
REQ-003 fill_req  in  1  request a line fill (sampled only in IDLE).
REQ-004 fill_addr  in  ADDRESS_SIZE  any block address inside the line to fetch.
REQ-005 wb_req  in  1  victim line is dirty and must be written back first (sampled with fill_req).
REQ-006 wb_addr  in  ADDRESS_SIZE  any block address inside the victim line.
REQ-007 wb_line  in  NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE  victim line data, block k in bits [k*BLOCK_SIZE +: BLOCK_SIZE].
REQ-008 mem_req  out  1  memory beat request; mem_we  out  1  1 = write beat, 0 = read beat.
REQ-009 mem_addr  out  ADDRESS_SIZE  beat block address; mem_wdata  out  BLOCK_SIZE  write data.
REQ-010 mem_ready  in  1  beat accepted/completed this cycle; mem_rdata  in  BLOCK_SIZE  read data valid when mem_ready is high on a read beat.
REQ-011 line_o  out  NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE  assembled line, same block packing as wb_line.
REQ-012 line_addr_o  out  ADDRESS_SIZE  line base address of line_o (offset bits zero).
REQ-013 write_line_o  out  1  one-cycle pulse: cache shall install {line_addr_o, line_o} as valid and clean.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, WRITEBACK, FILL and COMMIT.
REQ-016 In IDLE with fill_req=1, the block SHALL capture all request inputs at the same edge; it SHALL go to WRITEBACK if wb_req=1, otherwise to FILL.
REQ-017 fill_req while busy=1 SHALL be ignored and not queued.
REQ-018 Line base address SHALL be the address with its low log2(NUM_OF_BLOCKS_PER_LINE) bits forced to zero; beat k SHALL use base+k, with k running 0 to NUM_OF_BLOCKS_PER_LINE-1 in order.
REQ-019 In WRITEBACK and FILL, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL stay stable until a cycle where mem_ready=1 completes the beat.
REQ-020 A beat SHALL complete only on a cycle where mem_req=1 and mem_ready=1; mem_ready with mem_req=0 SHALL be ignored.
REQ-021 In WRITEBACK: mem_we=1 and mem_wdata = captured wb_line block k; after the last beat the FSM SHALL go to FILL and restart the beat counter at 0.
REQ-022 In FILL: mem_we=0 and mem_wdata=0; on each completed beat, mem_rdata SHALL be stored in line_o block k; after the last beat the FSM SHALL go to COMMIT.
REQ-023 In COMMIT, write_line_o SHALL be 1 for exactly one cycle, with line_addr_o equal to the fill base address; the FSM SHALL then return to IDLE.
REQ-024 A new fill_req can be accepted in the IDLE cycle that follows COMMIT.
REQ-025 line_o and line_addr_o SHALL hold their values from COMMIT until the next fill writes them.
REQ-026 With mem_ready held at 1, the first write_line_o cycle SHALL start 5 edges after the acceptance edge without writeback, and 9 edges after it with writeback (for 4 blocks per line).
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.
REQ-028 The beat counter SHALL be log2(NUM_OF_BLOCKS_PER_LINE) bits wide and wrap to 0 at each state change; base+k SHALL NOT carry into the index or tag bits.

Reset
REQ-029 While rst_n=0 at an edge: FSM SHALL go to IDLE; counter, mem_req, mem_we, mem_addr, mem_wdata, line_o, line_addr_o, write_line_o and busy SHALL all be 0.
REQ-030 Reset during any state SHALL abort the transfer immediately with no write_line_o; a partially assembled line SHALL be discarded.
REQ-031 The first request after reset release SHALL be accepted at the first edge with rst_n=1 and fill_req=1.

Verification
REQ-032 Clean fill: fill_addr=0x00000013, wb_req=0, mem_ready=1, memory returns 0xA0..0xA3 -> mem_addr 0x10,0x11,0x12,0x13 with mem_we=0; line_o=0x000000A3_000000A2_000000A1_000000A0; line_addr_o=0x10; write_line_o pulses once, 5 edges after acceptance.
REQ-033 Dirty fill: wb_req=1, wb_addr=0x25, wb_line blocks 0x11..0x14, fill_addr=0x40 -> four write beats to 0x24..0x27 carrying 0x11..0x14, then four read beats to 0x40..0x43; write_line_o pulses 9 edges after acceptance.
REQ-034 Stalled memory: mem_ready low for 3 cycles before each beat -> mem_addr/mem_wdata stay stable throughout each stall; line contents match the no-stall case; write_line_o still pulses exactly once.
REQ-035 Busy request: second fill_req pulse during FILL -> it is ignored; exactly one write_line_o; busy goes low for at least one cycle before any new acceptance.
REQ-036 Mid-operation reset: rst_n=0 after the second read beat -> all outputs are 0 on the next cycle; no write_line_o ever occurs; a fresh fill after release completes correctly.
